// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if
// Bundles the fetch sequencer's ALU-redirect, decode and instruction-memory
// signals.
//   master : the fetch sequencer (drives imem_req/imem_addr and the inst_* outputs)
//   slave  : the surrounding CPU/memory (drives redirect, stall, imem_ack/rdata)
interface pc_fetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] current_pc;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, current_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, current_pc
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Fetch sequencer between the PC and the instruction-memory port. It issues one
// req/ack fetch at a time. It holds each fetched instruction for decode until
// that instruction is consumed, and it applies branch/jump redirects. A
// redirect can arrive while a fetch is still outstanding.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : pc_fetch_ctrl_if.master
//          (redirect_valid/redirect_pc, stall, imem_req/imem_addr/imem_ack/
//           imem_rdata, inst_valid/inst/inst_pc, current_pc)
// Parameter:
//   RESET_PC : first fetch address after reset (word aligned)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pending_pc;
  logic        r_drop;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  assign w_redirect_pc = bus.redirect_pc & ALIGN_MASK;
  assign w_pc_plus4    = r_fetch_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_BOOT;
      r_fetch_pc   <= RESET_PC & ALIGN_MASK;
      r_pending_pc <= '0;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_FETCH;

        S_FETCH: begin
          if (bus.redirect_valid && bus.imem_ack) begin
            r_fetch_pc <= w_redirect_pc;
            r_drop     <= 1'b0;
          end else if (bus.redirect_valid) begin
            // imem_addr has to stay stable until the ack arrives. Save the
            // target here, and mark the outstanding word for discard.
            r_pending_pc <= w_redirect_pc;
            r_drop       <= 1'b1;
          end else if (bus.imem_ack && r_drop) begin
            r_fetch_pc <= r_pending_pc;
            r_drop     <= 1'b0;
          end else if (bus.imem_ack) begin
            r_inst       <= bus.imem_rdata;
            r_inst_pc    <= r_fetch_pc;
            r_inst_valid <= 1'b1;
            r_fetch_pc   <= w_pc_plus4;
            r_state      <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (bus.redirect_valid) begin
            r_fetch_pc   <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
          end else if (!bus.stall) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end

        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign bus.imem_req   = (r_state == S_FETCH);
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.current_pc = r_fetch_pc;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer sitting between the program counter and the instruction memory port of the CPU. It owns the fetch address register and issues one instruction-memory request at a time over a req/ack handshake. It presents each fetched instruction, with its PC, to decode until the instruction is consumed. It applies branch/jump redirects from the ALU, including a redirect that arrives while a fetch is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset. Bits [1:0] must be 0.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  redirect PC to redirect_pc (taken branch/jump).
- redirect_pc  in  32  redirect target from the ALU. Bits [1:0] are forced to 0 internally.
- stall  in  1  decode cannot accept the held instruction this cycle.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address. Equals current_pc.
- imem_ack  in  1  memory has returned data this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst  out  32  fetched instruction.
- inst_pc  out  32  address inst was fetched from.
- current_pc  out  32  fetch address register.

## Operation
- States:
  - BOOT: no request.
  - FETCH: imem_req=1.
  - HOLD: instruction is held on the outputs.
- imem_req = (state==FETCH). It is decoded combinationally from the state register.
- Internal registers:
  - fetch_pc: drives current_pc and imem_addr.
  - drop: discard flag for the outstanding fetch.
  - pending_pc: redirect target saved while a fetch is outstanding.
- Handshake rule: while imem_req=1 and imem_ack=0, imem_addr stays stable. A transaction completes on the edge where imem_ack=1.
- Transitions, listed in priority order at each rising edge:
  - BOOT → FETCH unconditionally. redirect_valid is ignored in BOOT.
  - redirect_valid=1 in HOLD: fetch_pc←redirect_pc, inst_valid←0, → FETCH.
  - redirect_valid=1 in FETCH with imem_ack=1: data discarded, fetch_pc←redirect_pc, drop←0, stay FETCH.
  - redirect_valid=1 in FETCH with imem_ack=0: pending_pc←redirect_pc, drop←1, fetch_pc unchanged, stay FETCH. A later redirect before the ack overwrites pending_pc.
  - FETCH, imem_ack=1, drop=1: data discarded, fetch_pc←pending_pc, drop←0, stay FETCH.
  - FETCH, imem_ack=1, drop=0: inst←imem_rdata, inst_pc←fetch_pc, inst_valid←1, fetch_pc←fetch_pc+4, → HOLD.
  - HOLD, stall=0: the instruction is consumed, inst_valid←0, → FETCH.
  - HOLD, stall=1: all outputs hold.
- stall is ignored outside HOLD.
- Arithmetic: fetch_pc+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0.

## Timing
- During reset (rst=0), asynchronously:
  - state=BOOT, fetch_pc=RESET_PC, pending_pc=0, drop=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- After rst rises:
  - The first rising edge moves BOOT→FETCH.
  - imem_req is first asserted in the following cycle, with imem_addr=RESET_PC.
- Zero-wait memory (ack in the same cycle as req), no stall: the FETCH/HOLD pattern repeats, giving one instruction per 2 cycles.
- inst_valid rises the cycle after the ack edge.
- Redirect-to-request latency:
  - In HOLD, or in FETCH coinciding with an ack: the new address is on imem_addr in the next cycle.
  - In FETCH without an ack: the new address appears the cycle after the outstanding ack.
- A discarded fetch never raises inst_valid.
- rst asserted mid-transaction abandons the transaction immediately. Memory must tolerate imem_req dropping without an ack.

## Test plan
- Reset/boot:
  - Stimulus: RESET_PC=32'h100, release rst, imem_ack tied 1.
  - Required: imem_req=0 for the first cycle after release, then imem_addr=0x100. Then inst_valid with inst_pc=0x100, then 0x104, 0x108, one every 2 cycles.
- Stall:
  - Stimulus: hold stall=1 for 3 cycles after inst_pc=0x104 appears.
  - Required: inst/inst_pc stable, imem_req=0. Fetch of 0x108 starts the cycle after stall drops.
- Redirect in HOLD:
  - Stimulus: redirect_valid with redirect_pc=0x2000 while inst_pc=0x104 is held.
  - Required: inst_valid=0 next cycle, imem_addr=0x2000. The next valid inst_pc=0x2000.
- Redirect during wait state:
  - Stimulus: memory delays ack 3 cycles on address 0x108; redirect to 0x400 arrives in wait cycle 1; a second redirect to 0x500 arrives in wait cycle 2.
  - Required: imem_addr stays 0x108 until the ack. The 0x108 data is discarded. The next request is 0x500, and the next inst_pc=0x500.
- Wrap and alignment:
  - Stimulus: redirect_pc=32'hFFFF_FFFE.
  - Required: fetch at 0xFFFF_FFFC, then the next fetch at 0x0000_0000.
- Async reset mid-fetch:
  - Stimulus: drop rst while imem_req=1 and ack is pending.
  - Required: imem_req and inst_valid go 0 without waiting for a clock edge, and current_pc=RESET_PC.
